pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute and memory access.
- Drives the 3-bit PC-update select of the program-counter block and the shared memory-port request and address select.
- Raises synchronous traps (ecall, ebreak, illegal opcode, memory timeout). Redirects the PC to mtvec, either directly or through a vector word read from memory.

Parameters:
- MTVEC_INDIRECT, 0: 0 = trap target is csr_mtvec (select 5). 1 = fetch the handler word at csr_mtvec, then load the PC from mem_dout (select 6).
- MEM_TIMEOUT, 0: maximum wait cycles for mem_ready. 0 = wait forever. 1..255 = access-fault trap on expiry.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- inst_opcode  in  7  instruction[6:0], valid from DECODE onward
- inst_funct3  in  3  instruction[14:12]
- inst_bit20  in  1  instruction[20] (0 = ecall, 1 = ebreak)
- mem_ready  in  1  memory completes the current request this cycle
- irq  in  1  external interrupt level (used only with the optional feature)
- irq_enable  in  1  mstatus.MIE
- pc_mux_sel  out  3  0 hold, 1 pc+4, 2 jal, 3 jalr, 4 branch, 5 mtvec, 6 mem_dout
- mem_req  out  1  memory request
- mem_we  out  1  store request
- mem_addr_sel  out  2  0 PC, 1 alu_out, 2 csr_mtvec
- ir_load  out  1  latch mem_dout into the instruction register
- rf_we  out  1  register-file write enable
- trap_taken  out  1  one-cycle pulse; CSR block saves mepc and mcause
- mcause  out  32  trap cause, valid while trap_taken = 1

Behaviour:
- Reset (reset == 0 at posedge):
  - state = FETCH, timeout counter = 0.
  - Reset overrides any state, including an outstanding memory request, which is abandoned.
  - During reset cycles all outputs are 0 (pc_mux_sel = 0).
- Default outputs: all outputs are 0 unless a state lists them. pc_mux_sel is applied by the PC block at the next edge.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - On mem_ready: ir_load = 1, go to DECODE.
- DECODE: one cycle, no outputs; go to EXEC.
- EXEC, by opcode (all complete in 1 cycle unless noted):
  - 0110111, 0010111, 0010011, 0110011: rf_we = 1, sel 1 → FETCH.
  - 1101111: rf_we = 1, sel 2 → FETCH.
  - 1100111: rf_we = 1, sel 3 → FETCH.
  - 1100011: sel 4 → FETCH. The taken/not-taken choice is made inside the PC block.
  - 0001111: sel 1 → FETCH (nop).
  - 0000011 / 0100011: no outputs → MEM.
  - 1110011 with funct3 != 0 (CSR): rf_we = 1, sel 1 → FETCH.
  - 1110011 with funct3 == 0 → TRAP with mcause 11 (inst_bit20 = 0) or 3 (inst_bit20 = 1).
  - Any other opcode → TRAP, mcause 2.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for a store.
  - On mem_ready: sel 1, and rf_we = 1 for a load → FETCH.
- TRAP:
  - trap_taken = 1, mcause is driven.
  - MTVEC_INDIRECT = 0: sel 5 → FETCH.
  - MTVEC_INDIRECT = 1: sel 0 → VEC.
- VEC:
  - mem_req = 1, mem_addr_sel = 2.
  - On mem_ready: sel 6 → FETCH.
  - A timeout in VEC returns to FETCH with sel 5. No nested trap.
- mcause register:
  - Loaded on the transition into TRAP; holds its value otherwise.
  - Reset value 0.
- Timeout counter (8-bit):
  - Counts cycles with mem_req = 1 and mem_ready = 0; clears on mem_ready or on a state change.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT in FETCH or MEM, with mem_ready still 0: drop mem_req next cycle, enter TRAP with mcause 1 (FETCH) or 5/7 (MEM load/store).
  - mem_ready in the same cycle as expiry wins: normal completion.
- Latency:
  - ALU, jump, branch: 3 cycles plus fetch wait.
  - Load/store: 4 cycles plus both waits.
  - Trap: adds 1 cycle, or 2 plus a wait when MTVEC_INDIRECT = 1.

Optional Feature:
- Macro PC_SEQ_CTRL_IRQ_EN.
- Defined:
  - In FETCH, on the first cycle only (counter == 0, before mem_ready), irq & irq_enable diverts the FSM to TRAP with mcause 0x8000000B.
  - No request is issued that cycle; mem_req = 0.
  - mepc equals the un-fetched PC because sel is 0.
- Undefined: irq and irq_enable are ignored, and the logic is absent.

Test Plan:
- Reset low 2 cycles mid-MEM, then release → state FETCH, mem_req = 1, mem_addr_sel = 0, pc_mux_sel = 0, no rf_we pulse.
- Opcode 0010011, mem_ready high in first FETCH cycle → ir_load at cycle 0, EXEC at cycle 2 with rf_we = 1 and sel = 1, FETCH again at cycle 3.
- Opcode 0000011, mem_ready delayed 3 cycles in MEM → mem_addr_sel = 1 for 4 cycles, mem_we = 0, rf_we = 1 and sel = 1 only on the ready cycle.
- Opcode 1110011, funct3 0, inst_bit20 1, MTVEC_INDIRECT = 1 → TRAP: trap_taken = 1, mcause = 3, sel 0. Then VEC: mem_addr_sel = 2, sel 6 on ready.
- MEM_TIMEOUT = 4, FETCH with mem_ready held 0 → mem_req drops after 4 wait cycles, trap_taken with mcause = 1, sel 5 (MTVEC_INDIRECT = 0).
- With PC_SEQ_CTRL_IRQ_EN, irq = 1 and irq_enable = 1 on FETCH entry → no mem_req, trap_taken, mcause = 0x8000000B. With irq_enable = 0 → normal fetch.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle fetch/decode/execute/memory sequencer for the RV32I core.
// Drives the PC-update select, the shared memory port and synchronous trap entry.
// Optional feature: define PC_SEQ_CTRL_IRQ_EN to let irq & irq_enable divert the
// first FETCH cycle into a trap with mcause 0x8000000B.
module pc_seq_ctrl #(
  parameter int unsigned MTVEC_INDIRECT = 0,
  parameter int unsigned MEM_TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  inst_opcode,
  input  logic [2:0]  inst_funct3,
  input  logic        inst_bit20,
  input  logic        mem_ready,
  input  logic        irq,
  input  logic        irq_enable,
  output logic [2:0]  pc_mux_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_addr_sel,
  output logic        ir_load,
  output logic        rf_we,
  output logic        trap_taken,
  output logic [31:0] mcause
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_TRAP,
    S_VEC
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t      state, state_nx;
  logic [7:0]  wait_cnt, wait_cnt_nx;
  logic [31:0] mcause_q, mcause_nx;
  logic        expire;
  logic        irq_take;
  logic        is_store;

  assign is_store = (inst_opcode == 7'b0100011);

  // This wait cycle is the one that brings the counter up to MEM_TIMEOUT.
  assign expire = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == TMO - 8'd1);

`ifdef PC_SEQ_CTRL_IRQ_EN
  assign irq_take = irq && irq_enable && (wait_cnt == '0);
`else
  logic unused_irq;
  assign unused_irq = irq & irq_enable;
  assign irq_take   = 1'b0;
`endif

  // Next-state, mcause capture and all control outputs; reset forces outputs low.
  always_comb begin
    state_nx     = state;
    mcause_nx    = mcause_q;
    pc_mux_sel   = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = '0;
    ir_load      = 1'b0;
    rf_we        = 1'b0;
    trap_taken   = 1'b0;
    mcause       = mcause_q;
    case (state)
      S_FETCH: begin
        if (irq_take) begin
          state_nx  = S_TRAP;
          mcause_nx = 32'h8000_000B;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load  = 1'b1;
            state_nx = S_DECODE;
          end else if (expire) begin
            state_nx  = S_TRAP;
            mcause_nx = 32'd1;
          end
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_FETCH;
        case (inst_opcode)
          7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: begin
            rf_we      = 1'b1;
            pc_mux_sel = 3'd1;
          end
          7'b1101111: begin
            rf_we      = 1'b1;
            pc_mux_sel = 3'd2;
          end
          7'b1100111: begin
            rf_we      = 1'b1;
            pc_mux_sel = 3'd3;
          end
          7'b1100011: pc_mux_sel = 3'd4;
          7'b0001111: pc_mux_sel = 3'd1;
          7'b0000011, 7'b0100011: state_nx = S_MEM;
          7'b1110011: begin
            if (inst_funct3 != 3'd0) begin
              rf_we      = 1'b1;
              pc_mux_sel = 3'd1;
            end else begin
              state_nx  = S_TRAP;
              mcause_nx = inst_bit20 ? 32'd3 : 32'd11;
            end
          end
          default: begin
            state_nx  = S_TRAP;
            mcause_nx = 32'd2;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 2'd1;
        mem_we       = is_store;
        if (mem_ready) begin
          pc_mux_sel = 3'd1;
          rf_we      = !is_store;
          state_nx   = S_FETCH;
        end else if (expire) begin
          state_nx  = S_TRAP;
          mcause_nx = is_store ? 32'd7 : 32'd5;
        end
      end
      S_TRAP: begin
        trap_taken = 1'b1;
        if (MTVEC_INDIRECT != 0) begin
          state_nx = S_VEC;
        end else begin
          pc_mux_sel = 3'd5;
          state_nx   = S_FETCH;
        end
      end
      S_VEC: begin
        mem_req      = 1'b1;
        mem_addr_sel = 2'd2;
        if (mem_ready) begin
          pc_mux_sel = 3'd6;
          state_nx   = S_FETCH;
        end else if (expire) begin
          pc_mux_sel = 3'd5;
          state_nx   = S_FETCH;
        end
      end
      default: state_nx = S_FETCH;
    endcase
    if (!reset) begin
      pc_mux_sel   = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = '0;
      ir_load      = 1'b0;
      rf_we        = 1'b0;
      trap_taken   = 1'b0;
      mcause       = '0;
    end
  end

  // Wait counter: counts unanswered request cycles, clears on ready or state change, saturates.
  always_comb begin
    wait_cnt_nx = wait_cnt;
    if ((state_nx != state) || mem_ready) begin
      wait_cnt_nx = '0;
    end else if (mem_req && (wait_cnt != '1)) begin
      wait_cnt_nx = wait_cnt + 8'd1;
    end
  end

  // State, wait counter and mcause registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      mcause_q <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      mcause_q <= mcause_nx;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: three instances with different trap and
// timeout configurations, a vector table for EXEC decoding, directed multi-cycle
// sequences and a randomized run against a behavioural reference model.
module tb_pc_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       b20;
  logic       rdy;
  logic       irq;
  logic       irq_en;

  logic [2:0]  sel_o  [3];
  logic        req_o  [3];
  logic        we_o   [3];
  logic [1:0]  asel_o [3];
  logic        irl_o  [3];
  logic        rf_o   [3];
  logic        trap_o [3];
  logic [31:0] mc_o   [3];

  int n_cmp = 0;
  int n_err = 0;

`ifdef PC_SEQ_CTRL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  always #5 clk = ~clk;

  // d0: direct mtvec, 4-cycle timeout; d1: vectored, wait forever; d2: vectored, 2-cycle timeout
  pc_seq_ctrl #(.MTVEC_INDIRECT(0), .MEM_TIMEOUT(4)) u_d0 (
    .clk(clk), .reset(reset), .inst_opcode(opc), .inst_funct3(f3), .inst_bit20(b20),
    .mem_ready(rdy), .irq(irq), .irq_enable(irq_en), .pc_mux_sel(sel_o[0]),
    .mem_req(req_o[0]), .mem_we(we_o[0]), .mem_addr_sel(asel_o[0]), .ir_load(irl_o[0]),
    .rf_we(rf_o[0]), .trap_taken(trap_o[0]), .mcause(mc_o[0]));

  pc_seq_ctrl #(.MTVEC_INDIRECT(1), .MEM_TIMEOUT(0)) u_d1 (
    .clk(clk), .reset(reset), .inst_opcode(opc), .inst_funct3(f3), .inst_bit20(b20),
    .mem_ready(rdy), .irq(irq), .irq_enable(irq_en), .pc_mux_sel(sel_o[1]),
    .mem_req(req_o[1]), .mem_we(we_o[1]), .mem_addr_sel(asel_o[1]), .ir_load(irl_o[1]),
    .rf_we(rf_o[1]), .trap_taken(trap_o[1]), .mcause(mc_o[1]));

  pc_seq_ctrl #(.MTVEC_INDIRECT(1), .MEM_TIMEOUT(2)) u_d2 (
    .clk(clk), .reset(reset), .inst_opcode(opc), .inst_funct3(f3), .inst_bit20(b20),
    .mem_ready(rdy), .irq(irq), .irq_enable(irq_en), .pc_mux_sel(sel_o[2]),
    .mem_req(req_o[2]), .mem_we(we_o[2]), .mem_addr_sel(asel_o[2]), .ir_load(irl_o[2]),
    .rf_we(rf_o[2]), .trap_taken(trap_o[2]), .mcause(mc_o[2]));

  typedef struct packed {
    logic [2:0]  sel;
    logic        req;
    logic        we;
    logic [1:0]  asel;
    logic        irl;
    logic        rf;
    logic        trap;
    logic [31:0] mc;
  } obs_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        b20;
    logic        rf;
    logic [2:0]  sel;
    logic        trap;
    logic [31:0] cause;
  } vec_t;

  typedef struct {
    logic [6:0] op;
    logic       rf;
    logic [2:0] sel;
  } retire_t;

  vec_t    vecs [15];
  retire_t rtab [8];

  function automatic obs_t obs_of(input int k);
    return {sel_o[k], req_o[k], we_o[k], asel_o[k], irl_o[k], rf_o[k], trap_o[k], mc_o[k]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // All control outputs low; mcause included only when requested.
  task automatic chk_quiet(input string nm, input int k, input bit with_mc);
    obs_t a;
    a = obs_of(k);
    if (!with_mc) a.mc = '0;
    n_cmp++;
    if (a !== '0) begin
      n_err++;
      $display("FAIL %s: got %h, want all-zero outputs", nm, a);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    rdy    = 1'b0;
    irq    = 1'b0;
    irq_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic to_exec(input logic [6:0] o, input logic [2:0] f, input logic b);
    opc = o;
    f3  = f;
    b20 = b;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
  endtask

  // ---------------- reference model ----------------
  localparam int P_F = 0, P_D = 1, P_X = 2, P_M = 3, P_T = 4, P_V = 5;
  int          mph [3];
  int          mw  [3];
  logic [31:0] mmc [3];

  function automatic int lim_of(input int k);
    case (k)
      0:       return 4;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic void predict(input int k, output obs_t e, output int nph,
                                  output int nw, output logic [31:0] nmc);
    bit late;
    bit hit;
    int cur;
    cur = mph[k];
    e   = '0;
    nph = cur;
    nmc = mmc[k];
    nw  = 0;
    if (reset === 1'b0) begin
      nph = P_F;
      nmc = '0;
      return;
    end
    // allowance used up: this unanswered cycle is number lim_of(k)
    late = (lim_of(k) != 0) && !rdy && (mw[k] + 1 >= lim_of(k));
    case (cur)
      P_F: begin
        if (IRQ_ON && irq && irq_en && mw[k] == 0) begin
          nph = P_T;
          nmc = 32'h8000_000B;
        end else begin
          e.req = 1'b1;
          if (rdy) begin
            e.irl = 1'b1;
            nph   = P_D;
          end else if (late) begin
            nph = P_T;
            nmc = 32'd1;
          end
        end
      end
      P_D: nph = P_X;
      P_X: begin
        hit = 1'b0;
        foreach (rtab[i]) begin
          if (rtab[i].op == opc) begin
            hit   = 1'b1;
            e.rf  = rtab[i].rf;
            e.sel = rtab[i].sel;
            nph   = P_F;
          end
        end
        if (!hit) begin
          if (opc == OP_LOAD || opc == OP_STORE) begin
            nph = P_M;
          end else if (opc == OP_SYS && f3 != 3'd0) begin
            e.rf  = 1'b1;
            e.sel = 3'd1;
            nph   = P_F;
          end else if (opc == OP_SYS) begin
            nph = P_T;
            nmc = b20 ? 32'd3 : 32'd11;
          end else begin
            nph = P_T;
            nmc = 32'd2;
          end
        end
      end
      P_M: begin
        e.req  = 1'b1;
        e.asel = 2'd1;
        e.we   = (opc == OP_STORE);
        if (rdy) begin
          e.sel = 3'd1;
          e.rf  = (opc != OP_STORE);
          nph   = P_F;
        end else if (late) begin
          nph = P_T;
          nmc = (opc == OP_STORE) ? 32'd7 : 32'd5;
        end
      end
      P_T: begin
        e.trap = 1'b1;
        e.mc   = mmc[k];
        if (k != 0) begin
          nph = P_V;
        end else begin
          e.sel = 3'd5;
          nph   = P_F;
        end
      end
      default: begin
        e.req  = 1'b1;
        e.asel = 2'd2;
        if (rdy) begin
          e.sel = 3'd6;
          nph   = P_F;
        end else if (late) begin
          e.sel = 3'd5;
          nph   = P_F;
        end
      end
    endcase
    if (nph != cur || rdy)  nw = 0;
    else if (e.req)         nw = (mw[k] >= 255) ? 255 : mw[k] + 1;
    else                    nw = mw[k];
  endfunction

  initial begin
    logic [6:0]  ops [11];
    obs_t        e;
    obs_t        a;
    int          nph [3];
    int          nw  [3];
    logic [31:0] nmc [3];

    vecs[0]  = '{7'b0110111, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 32'd0};
    vecs[1]  = '{7'b0010111, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 32'd0};
    vecs[2]  = '{7'b0010011, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 32'd0};
    vecs[3]  = '{7'b0110011, 3'd5, 1'b1, 1'b1, 3'd1, 1'b0, 32'd0};
    vecs[4]  = '{7'b1101111, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 32'd0};
    vecs[5]  = '{7'b1100111, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 32'd0};
    vecs[6]  = '{7'b1100011, 3'd1, 1'b0, 1'b0, 3'd4, 1'b0, 32'd0};
    vecs[7]  = '{7'b0001111, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0, 32'd0};
    vecs[8]  = '{7'b1110011, 3'd1, 1'b0, 1'b1, 3'd1, 1'b0, 32'd0};
    vecs[9]  = '{7'b1110011, 3'd7, 1'b1, 1'b1, 3'd1, 1'b0, 32'd0};
    vecs[10] = '{7'b1110011, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 32'd11};
    vecs[11] = '{7'b1110011, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 32'd3};
    vecs[12] = '{7'b0000000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 32'd2};
    vecs[13] = '{7'b1111111, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 32'd2};
    vecs[14] = '{7'b0110100, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 32'd2};

    rtab[0] = '{7'b0110111, 1'b1, 3'd1};
    rtab[1] = '{7'b0010111, 1'b1, 3'd1};
    rtab[2] = '{7'b0010011, 1'b1, 3'd1};
    rtab[3] = '{7'b0110011, 1'b1, 3'd1};
    rtab[4] = '{7'b1101111, 1'b1, 3'd2};
    rtab[5] = '{7'b1100111, 1'b1, 3'd3};
    rtab[6] = '{7'b1100011, 1'b0, 3'd4};
    rtab[7] = '{7'b0001111, 1'b0, 3'd1};

    ops = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0001111, OP_LOAD, OP_STORE, OP_SYS};

    opc = '0; f3 = '0; b20 = 1'b0;
    do_reset();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk_quiet($sformatf("reset outputs d%0d", k), k, 1'b1);
    reset = 1'b1;

    // ---- table: EXEC decoding on the direct-mtvec instance ----
    for (int i = 0; i < 15; i++) begin
      do_reset();
      opc = vecs[i].op; f3 = vecs[i].f3; b20 = vecs[i].b20; rdy = 1'b1;
      #1;
      chk($sformatf("vec%0d fetch ir_load", i), 32'(irl_o[0]), 32'd1);
      chk($sformatf("vec%0d fetch req", i), 32'(req_o[0]), 32'd1);
      tick();
      rdy = 1'b0;
      #1;
      chk_quiet($sformatf("vec%0d decode", i), 0, 1'b0);
      tick();
      #1;
      chk($sformatf("vec%0d exec rf_we", i), 32'(rf_o[0]), 32'(vecs[i].rf));
      chk($sformatf("vec%0d exec sel", i), 32'(sel_o[0]), 32'(vecs[i].sel));
      chk($sformatf("vec%0d exec req", i), 32'(req_o[0]), 32'd0);
      tick();
      if (vecs[i].trap) begin
        #1;
        chk($sformatf("vec%0d trap_taken", i), 32'(trap_o[0]), 32'd1);
        chk($sformatf("vec%0d mcause", i), mc_o[0], vecs[i].cause);
        chk($sformatf("vec%0d trap sel", i), 32'(sel_o[0]), 32'd5);
        tick();
      end
      #1;
      chk($sformatf("vec%0d refetch req", i), 32'(req_o[0]), 32'd1);
      chk($sformatf("vec%0d refetch asel", i), 32'(asel_o[0]), 32'd0);
    end

    // ---- reset in the middle of MEM abandons the access ----
    do_reset();
    to_exec(OP_LOAD, 3'd2, 1'b0);
    tick();
    #1;
    chk("midmem req", 32'(req_o[0]), 32'd1);
    chk("midmem asel", 32'(asel_o[0]), 32'd1);
    reset = 1'b0;
    rdy   = 1'b1;
    #1;
    chk_quiet("midmem reset cycle 1", 0, 1'b1);
    tick();
    #1;
    chk_quiet("midmem reset cycle 2", 0, 1'b1);
    tick();
    reset = 1'b1;
    rdy   = 1'b0;
    #1;
    chk("post reset req", 32'(req_o[0]), 32'd1);
    chk("post reset asel", 32'(asel_o[0]), 32'd0);
    chk("post reset sel", 32'(sel_o[0]), 32'd0);
    chk("post reset rf_we", 32'(rf_o[0]), 32'd0);

    // ---- load answered on the last allowed wait cycle ----
    do_reset();
    to_exec(OP_LOAD, 3'd2, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      rdy = (i == 3);
      #1;
      chk($sformatf("load wait%0d asel", i), 32'(asel_o[0]), 32'd1);
      chk($sformatf("load wait%0d we", i), 32'(we_o[0]), 32'd0);
      chk($sformatf("load wait%0d rf_we", i), 32'(rf_o[0]), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("load wait%0d sel", i), 32'(sel_o[0]), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    rdy = 1'b0;
    #1;
    chk("load then fetch asel", 32'(asel_o[0]), 32'd0);
    chk("load then fetch req", 32'(req_o[0]), 32'd1);

    // ---- store immediate completion, then store timeout ----
    do_reset();
    to_exec(OP_STORE, 3'd2, 1'b0);
    tick();
    rdy = 1'b1;
    #1;
    chk("store we", 32'(we_o[0]), 32'd1);
    chk("store rf_we", 32'(rf_o[0]), 32'd0);
    chk("store sel", 32'(sel_o[0]), 32'd1);
    do_reset();
    to_exec(OP_STORE, 3'd2, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("store tmo wait%0d req", i), 32'(req_o[0]), 32'd1);
      tick();
    end
    #1;
    chk("store tmo req drop", 32'(req_o[0]), 32'd0);
    chk("store tmo trap", 32'(trap_o[0]), 32'd1);
    chk("store tmo mcause", mc_o[0], 32'd7);
    chk("store tmo sel", 32'(sel_o[0]), 32'd5);

    // ---- fetch timeout, direct mtvec ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fetch tmo wait%0d req", i), 32'(req_o[0]), 32'd1);
      tick();
    end
    #1;
    chk("fetch tmo req drop", 32'(req_o[0]), 32'd0);
    chk("fetch tmo trap", 32'(trap_o[0]), 32'd1);
    chk("fetch tmo mcause", mc_o[0], 32'd1);
    chk("fetch tmo sel", 32'(sel_o[0]), 32'd5);
    tick();
    #1;
    chk("fetch tmo refetch", 32'(req_o[0]), 32'd1);

    // ---- ebreak through vectored mtvec (d1 waits forever, d2 times out in VEC) ----
    do_reset();
    to_exec(OP_SYS, 3'd0, 1'b1);
    #1;
    chk_quiet("ebreak exec d1", 1, 1'b0);
    tick();
    #1;
    chk("ebreak trap d1", 32'(trap_o[1]), 32'd1);
    chk("ebreak mcause d1", mc_o[1], 32'd3);
    chk("ebreak sel d1", 32'(sel_o[1]), 32'd0);
    chk("ebreak sel d0", 32'(sel_o[0]), 32'd5);
    chk("ebreak mcause d0", mc_o[0], 32'd3);
    tick();
    #1;
    chk("vec0 asel d1", 32'(asel_o[1]), 32'd2);
    chk("vec0 req d1", 32'(req_o[1]), 32'd1);
    chk("vec0 sel d2", 32'(sel_o[2]), 32'd0);
    tick();
    #1;
    chk("vec1 sel d1", 32'(sel_o[1]), 32'd0);
    chk("vec1 timeout sel d2", 32'(sel_o[2]), 32'd5);
    chk("vec1 timeout trap d2", 32'(trap_o[2]), 32'd0);
    tick();
    #1;
    chk("vec2 asel d1", 32'(asel_o[1]), 32'd2);
    chk("vec2 refetch asel d2", 32'(asel_o[2]), 32'd0);
    tick();
    rdy = 1'b1;
    #1;
    chk("vec ready sel d1", 32'(sel_o[1]), 32'd6);
    tick();
    rdy = 1'b0;
    #1;
    chk("vec done asel d1", 32'(asel_o[1]), 32'd0);
    chk("vec done req d1", 32'(req_o[1]), 32'd1);

    // ---- external interrupt on FETCH entry ----
    do_reset();
    irq = 1'b1;
    irq_en = 1'b1;
    #1;
`ifdef PC_SEQ_CTRL_IRQ_EN
    chk("irq fetch no req", 32'(req_o[0]), 32'd0);
    chk("irq fetch sel", 32'(sel_o[0]), 32'd0);
    tick();
    #1;
    chk("irq trap", 32'(trap_o[0]), 32'd1);
    chk("irq mcause", mc_o[0], 32'h8000_000B);
    chk("irq trap sel", 32'(sel_o[0]), 32'd5);
    irq_en = 1'b0;
    tick();
    #1;
    chk("irq masked fetch req", 32'(req_o[0]), 32'd1);
    tick();
    irq_en = 1'b1;
    #1;
    chk("irq late cycle ignored", 32'(req_o[0]), 32'd1);
`else
    chk("irq ignored req", 32'(req_o[0]), 32'd1);
    chk("irq ignored trap", 32'(trap_o[0]), 32'd0);
    tick();
    #1;
    chk("irq ignored still fetching", 32'(req_o[0]), 32'd1);
`endif

    // ---- randomized run against the reference model ----
    for (int k = 0; k < 3; k++) begin
      mph[k] = P_F;
      mw[k]  = 0;
      mmc[k] = '0;
    end
    for (int c = 0; c < 4000; c++) begin
      reset  = (c < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      opc    = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 10)] : 7'($urandom);
      f3     = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      b20    = 1'($urandom_range(0, 1));
      rdy    = ($urandom_range(0, 99) < 45);
      irq    = ($urandom_range(0, 99) < 30);
      irq_en = ($urandom_range(0, 1) == 1);
      #1;
      for (int k = 0; k < 3; k++) begin
        predict(k, e, nph[k], nw[k], nmc[k]);
        a = obs_of(k);
        if (!e.trap) a.mc = '0;
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL rand d%0d cycle %0d: got %h, want %h", k, c, a, e);
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        mph[k] = nph[k];
        mw[k]  = nw[k];
        mmc[k] = nmc[k];
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
